// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and default timing constants
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with restart, end-of-bit tick and pre-tick
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] count;

  // bit_tick marks the final clk of a bit; pre_tick the clk before it
  assign bit_tick = (count == CNT_LAST);
  assign pre_tick = (count == CNT_PRE);

  // Count 0..CLKS_PER_BIT-1, wrapping on every bit boundary; restart aligns a new frame
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count <= '0;
    end else if (bit_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// rtl/uart_tx_fifo_reader.sv - UART transmitter draining a show-ahead FIFO read port
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  uart_state_t          state, state_next;
  logic [DATA_BITS-1:0] shreg, shreg_next, shreg_shift;
  logic [BCW-1:0]       bit_cnt, bit_cnt_next;
  logic                 stop_cnt, stop_cnt_next;
  logic                 parity_bit, parity_next;
  logic                 tx_next, busy_next, frame_done_next;
  logic                 bit_tick, pre_tick, last_stop;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (fifo_rd_en),
    .bit_tick(bit_tick),
    .pre_tick(pre_tick)
  );

  // The pop strobe is combinational so the byte is latched on the same edge it leaves the FIFO
  assign last_stop   = (state == S_STOP) && bit_tick && (stop_cnt == STOP_LAST);
  assign fifo_rd_en  = !reset && !fifo_empty && ((state == S_IDLE) || last_stop);
  assign shreg_shift = shreg >> 1;

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_next      = state;
    shreg_next      = shreg;
    bit_cnt_next    = bit_cnt;
    stop_cnt_next   = stop_cnt;
    parity_next     = parity_bit;
    tx_next         = tx;
    busy_next       = busy;
    frame_done_next = 1'b0;

    case (state)
      S_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
      end
      S_START: begin
        if (bit_tick) begin
          state_next   = S_DATA;
          bit_cnt_next = '0;
          tx_next      = shreg[0];
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bit_cnt == BIT_LAST) begin
            stop_cnt_next = 1'b0;
            if (PARITY_EN != 0) begin
              state_next = S_PARITY;
              tx_next    = parity_bit;
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
            shreg_next   = shreg_shift;
            tx_next      = shreg_shift[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          state_next    = S_STOP;
          stop_cnt_next = 1'b0;
          tx_next       = 1'b1;
        end
      end
      S_STOP: begin
        // frame_done is registered, so it is raised one clk early to land on the last stop clk
        if (pre_tick && (stop_cnt == STOP_LAST)) begin
          frame_done_next = 1'b1;
        end
        if (bit_tick) begin
          if (stop_cnt == STOP_LAST) begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
          end else begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase

    // A pop overrides the above: load the byte and start a frame with no idle gap
    if (fifo_rd_en) begin
      state_next    = S_START;
      shreg_next    = fifo_dout;
      parity_next   = (PARITY_ODD != 0) ? ~^fifo_dout : ^fifo_dout;
      bit_cnt_next  = '0;
      stop_cnt_next = 1'b0;
      tx_next       = 1'b0;
      busy_next     = 1'b1;
    end
  end

  // State and datapath registers; reset drops any in-flight byte
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      bit_cnt    <= bit_cnt_next;
      stop_cnt   <= stop_cnt_next;
      parity_bit <= parity_next;
      tx         <= tx_next;
      busy       <= busy_next;
      frame_done <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb/tb_uart_tx_fifo_reader.sv - self-checking bench for uart_tx_fifo_reader
module tb_uart_tx_fifo_reader;

  localparam int CPB  = 4;
  localparam int NONE = 4;

  logic       clk;
  logic [3:0] rst;
  logic [3:0] fempty;
  logic [3:0] rd_en;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [3:0] fd;
  logic [7:0] head;
  logic [7:0] fq[$];
  logic [7:0] frame_bytes[3];
  logic       pop_flag;
  int         sel;
  int         checks;
  int         failures;

  // Instance 0: 8N1, 1: even parity, 2: odd parity, 3: two stop bits
  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) d0 (
    .clk(clk), .reset(rst[0]), .fifo_empty(fempty[0]), .fifo_dout(head),
    .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(fd[0]));
  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) d1 (
    .clk(clk), .reset(rst[1]), .fifo_empty(fempty[1]), .fifo_dout(head),
    .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(fd[1]));
  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) d2 (
    .clk(clk), .reset(rst[2]), .fifo_empty(fempty[2]), .fifo_dout(head),
    .fifo_rd_en(rd_en[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(fd[2]));
  uart_tx_fifo_reader #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) d3 (
    .clk(clk), .reset(rst[3]), .fifo_empty(fempty[3]), .fifo_dout(head),
    .fifo_rd_en(rd_en[3]), .tx(tx[3]), .busy(busy[3]), .frame_done(fd[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pe(input int idx);
    return (idx == 1 || idx == 2) ? 1 : 0;
  endfunction

  function automatic int po(input int idx);
    return (idx == 2) ? 1 : 0;
  endfunction

  function automatic int sb(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int idx);
    return (1 + 8 + pe(idx) + sb(idx)) * CPB;
  endfunction

  // Expected line level at a given clk offset inside a frame
  function automatic logic exp_bit(input int idx, input logic [7:0] b, input int pos);
    int bitn;
    bitn = pos / CPB;
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return b[bitn-1];
    if (pe(idx) == 1 && bitn == 9) return (($countones(b) % 2) == 1) ^ (po(idx) == 1);
    return 1'b1;
  endfunction

  // Show-ahead FIFO model: only the selected instance sees a non-empty FIFO
  task automatic fifo_refresh();
    for (int i = 0; i < 4; i++) fempty[i] = !((sel == i) && (fq.size() > 0));
    head = (fq.size() > 0) ? fq[0] : 8'($urandom);
  endtask

  // Capture the pop strobe mid-cycle when it is stable
  always @(negedge clk) begin
    #2;
    pop_flag = (sel < 4) ? rd_en[sel[1:0]] : 1'b0;
  end

  // Apply the pop just after the edge the DUT latched on
  always @(posedge clk) begin
    #1;
    if (pop_flag && fq.size() > 0) void'(fq.pop_front());
    pop_flag = 1'b0;
    fifo_refresh();
  end

  task automatic chk(input string name, input int t, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%b expected=%b", name, t, got, exp);
    end
  endtask

  task automatic run_frames(input int idx, input int n, input string name);
    int f, total, k, pos;
    logic ex_tx, ex_busy, ex_fd, ex_rd;
    f = frame_len(idx);
    total = n * f;
    @(negedge clk);
    sel = idx;
    for (int i = 0; i < n; i++) fq.push_back(frame_bytes[i]);
    fifo_refresh();
    for (int t = 0; t <= total + 4; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      ex_rd = (t == 0) || (t > 0 && t < total && (t % f) == 0);
      if (t >= 1 && t <= total) begin
        k = (t - 1) / f;
        pos = (t - 1) % f;
        ex_tx = exp_bit(idx, frame_bytes[k], pos);
        ex_busy = 1'b1;
        ex_fd = (pos == f - 1);
      end else begin
        ex_tx = 1'b1;
        ex_busy = 1'b0;
        ex_fd = 1'b0;
      end
      chk({name, "_rd_en"}, t, rd_en[idx], ex_rd);
      chk({name, "_tx"}, t, tx[idx], ex_tx);
      chk({name, "_busy"}, t, busy[idx], ex_busy);
      chk({name, "_frame_done"}, t, fd[idx], ex_fd);
    end
    checks++;
    if (fq.size() != 0) begin
      failures++;
      $display("FAIL %s_fifo_drained got=%0d expected=0", name, fq.size());
    end
    sel = NONE;
    fifo_refresh();
  endtask

  task automatic test_reset();
    rst = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_tx", i, tx[i], 1'b1);
      chk("reset_busy", i, busy[i], 1'b0);
      chk("reset_frame_done", i, fd[i], 1'b0);
      chk("reset_rd_en", i, rd_en[i], 1'b0);
    end
    @(negedge clk);
    rst = 4'h0;
  endtask

  task automatic test_basic();
    frame_bytes[0] = 8'hA5;
    run_frames(0, 1, "basic_a5");
  endtask

  task automatic test_parity();
    frame_bytes[0] = 8'h07;
    run_frames(1, 1, "parity_even");
    run_frames(2, 1, "parity_odd");
  endtask

  task automatic test_back_to_back();
    frame_bytes[0] = 8'h55;
    frame_bytes[1] = 8'h0F;
    run_frames(0, 2, "b2b");
  endtask

  task automatic test_two_stop();
    frame_bytes[0] = 8'hFF;
    run_frames(3, 1, "two_stop");
  endtask

  task automatic test_random();
    int idx, n;
    for (int it = 0; it < 8; it++) begin
      idx = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 3; i++) frame_bytes[i] = 8'($urandom);
      run_frames(idx, n, "random");
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'hC3;
    @(negedge clk);
    sel = 0;
    fq.push_back(b);
    fifo_refresh();
    for (int t = 0; t <= 17; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (t == 0) chk("midrst_rd_en", t, rd_en[0], 1'b1);
      else chk("midrst_tx", t, tx[0], exp_bit(0, b, t - 1));
    end
    // Reset during data bit 3 with another byte waiting in the FIFO
    @(negedge clk);
    rst[0] = 1'b1;
    fq.push_back(8'h3C);
    fifo_refresh();
    for (int t = 18; t <= 21; t++) begin
      if (t > 18) @(negedge clk);
      #1;
      chk("midrst_no_pop", t, rd_en[0], 1'b0);
      if (t > 18) begin
        chk("midrst_tx_high", t, tx[0], 1'b1);
        chk("midrst_busy_low", t, busy[0], 1'b0);
      end
    end
    @(negedge clk);
    fq.delete();
    fifo_refresh();
    rst[0] = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      #1;
      chk("post_rst_tx", t, tx[0], 1'b1);
      chk("post_rst_rd_en", t, rd_en[0], 1'b0);
      chk("post_rst_busy", t, busy[0], 1'b0);
    end
    sel = NONE;
    fifo_refresh();
  endtask

  task automatic test_empty_idle();
    @(negedge clk);
    sel = 0;
    fifo_refresh();
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      #1;
      chk("empty_rd_en", t, rd_en[0], 1'b0);
      chk("empty_tx", t, tx[0], 1'b1);
      chk("empty_busy", t, busy[0], 1'b0);
      chk("empty_frame_done", t, fd[0], 1'b0);
    end
    sel = NONE;
    fifo_refresh();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    sel = NONE;
    pop_flag = 1'b0;
    rst = 4'hF;
    fifo_refresh();
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_two_stop();
    test_random();
    test_reset_mid_frame();
    test_empty_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
